// File: rtl/digit_serial_addsub.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands consumed DIGIT bits per clock
// through a DIGIT-wide ripple chain, with a start/busy/done handshake.

module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module digit_serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] opa, opb, acc, acc_n;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [DIGIT:0]   c;
    logic [DIGIT-1:0] psum;
    logic [WIDTH+DIGIT-1:0] acc_sh;
    logic             accept, last;

    // One full-adder cell per bit of the digit; c[] is the ripple chain.
    assign c[0] = carry;
    generate
        for (genvar i = 0; i < DIGIT; i++) begin : g_fa
            fa_cell u_fa (
                .a  (opa[i]),
                .b  (opb[i]),
                .ci (c[i]),
                .s  (psum[i]),
                .co (c[i+1])
            );
        end
    endgenerate

    // New digit enters at the top; after N digits the accumulator holds the result.
    assign acc_sh = {psum, acc} >> DIGIT;
    assign acc_n  = acc_sh[WIDTH-1:0];

    assign accept = ((state == IDLE) || (state == DONE)) && start;
    assign last   = (state == BUSY) && (cnt == CW'(N - 1));

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = BUSY;
            BUSY:    if (last) state_n = DONE;
            DONE:    state_n = start ? BUSY : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            opa   <= '0;
            opb   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= (state_n == BUSY);
            done  <= last;
            if (accept) begin
                // Subtract as a + ~b + 1; borrow-in becomes an inverted carry-in.
                opa   <= a;
                opb   <= b ^ {WIDTH{sub}};
                carry <= cin ^ sub;
                cnt   <= '0;
            end else if (state == BUSY) begin
                opa   <= opa >> DIGIT;
                opb   <= opb >> DIGIT;
                acc   <= acc_n;
                carry <= c[DIGIT];
                cnt   <= cnt + CW'(1);
            end
            if (last) begin
                sum  <= acc_n;
                cout <= c[DIGIT];
                ovf  <= c[DIGIT] ^ c[DIGIT-1];
            end
        end
    end
endmodule
